// File: rtl/uart_frame_streamer_if.sv
// uart_frame_streamer_if
//   Groups the pixel-capture input bus and the UART transmitter handshake
//   that the frame streamer sits between.
//
//   PIX_DATA     pixel byte from the capture path
//   PIX_VALID    PIX_DATA valid this cycle
//   FRAME_START  first pixel of a frame (only meaningful with PIX_VALID)
//   TX_IDLE      IDLE from the UART transmitter
//   TX_DATA      byte presented to the transmitter (DATA)
//   TX_READY     one-cycle send strobe (DATA_READY)
//
//   master : the streamer (drives TX_DATA / TX_READY)
//   slave  : the surrounding pixel source and transmitter
interface uart_frame_streamer_if;
  logic [7:0] PIX_DATA;
  logic       PIX_VALID;
  logic       FRAME_START;
  logic       TX_IDLE;
  logic [7:0] TX_DATA;
  logic       TX_READY;

  modport master (
    input  PIX_DATA,
    input  PIX_VALID,
    input  FRAME_START,
    input  TX_IDLE,
    output TX_DATA,
    output TX_READY
  );

  modport slave (
    output PIX_DATA,
    output PIX_VALID,
    output FRAME_START,
    output TX_IDLE,
    input  TX_DATA,
    input  TX_READY
  );
endinterface

// File: rtl/uart_frame_streamer.sv
// uart_frame_streamer
//   Byte-stream front end for the UART transmitter. Pixel bytes are
//   buffered in a 2^DEPTH_LOG2 entry FIFO of {sof, byte}; a read FSM hands
//   them one at a time to the transmitter, inserting a SYNC0/SYNC1 header
//   ahead of every frame-start pixel. With CLAMP=1 a pixel equal to SYNC0 is
//   stored as SYNC0-1 so the header byte never shows up in the payload.
//
//   CLK         system clock, rising edge
//   RST_N       synchronous active-low reset
//   sif         pixel input bus + transmitter handshake (master side)
//   FIFO_COUNT  registered FIFO occupancy, 0..2^DEPTH_LOG2
//   FIFO_FULL   FIFO_COUNT == 2^DEPTH_LOG2
//   OVERFLOW    sticky: a valid pixel was dropped; cleared only by reset
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | waiting for FIFO data; pops the head into the holding reg
// SYNC0    | sending first header byte
// SYNC1    | sending second header byte
// BYTE     | sending the held payload byte
module uart_frame_streamer #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] SYNC0      = 8'hFF,
  parameter logic [7:0] SYNC1      = 8'h00,
  parameter bit         CLAMP      = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  uart_frame_streamer_if.master sif,
  output logic [DEPTH_LOG2:0]   FIFO_COUNT,
  output logic                  FIFO_FULL,
  output logic                  OVERFLOW
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_SYNC0 = 2'd1,
    ST_SYNC1 = 2'd2,
    ST_BYTE  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [8:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  overflow_q;
  logic                  push;
  logic                  pop;
  logic [7:0]            pix_byte;
  logic [8:0]            head;

  // read FSM
  state_t     state;
  state_t     state_nxt;
  logic [7:0] hold_q;
  logic [7:0] hold_nxt;
  logic [7:0] tx_data_q;
  logic [7:0] tx_data_nxt;
  logic       tx_ready_q;
  logic       tx_ready_nxt;

  assign full = (count == DEPTH_CNT);
  assign head = mem[rd_ptr];

  always_comb begin
    pix_byte = sif.PIX_DATA;
    if (CLAMP && (sif.PIX_DATA == SYNC0)) begin
      pix_byte = SYNC0 - 8'd1;
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  // An empty FIFO never pops (FETCH requires count != 0), so a push into
  // an empty FIFO is simply stored.
  assign push = sif.PIX_VALID && (!full || pop);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {sif.FRAME_START, pix_byte};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (sif.PIX_VALID && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= ST_FETCH;
      hold_q     <= '0;
      tx_data_q  <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_q     <= hold_nxt;
      tx_data_q  <= tx_data_nxt;
      tx_ready_q <= tx_ready_nxt;
    end
  end

  // TX_DATA is loaded on the edge that enters a send state so it is already
  // stable in the state's first cycle. The strobe is raised only from
  // TX_READY=0 with IDLE seen; the cycle it is high is the acceptance
  // cycle, after which it drops and the state advances.
  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_q;
    tx_data_nxt  = tx_data_q;
    tx_ready_nxt = 1'b0;
    pop          = 1'b0;
    case (state)
      ST_FETCH: begin
        if (count != '0) begin
          pop      = 1'b1;
          hold_nxt = head[7:0];
          if (head[8]) begin
            state_nxt   = ST_SYNC0;
            tx_data_nxt = SYNC0;
          end else begin
            state_nxt   = ST_BYTE;
            tx_data_nxt = head[7:0];
          end
        end
      end
      default: begin
        if (tx_ready_q) begin
          case (state)
            ST_SYNC0: begin
              state_nxt   = ST_SYNC1;
              tx_data_nxt = SYNC1;
            end
            ST_SYNC1: begin
              state_nxt   = ST_BYTE;
              tx_data_nxt = hold_q;
            end
            default: begin
              state_nxt = ST_FETCH;
            end
          endcase
        end else begin
          tx_ready_nxt = sif.TX_IDLE;
        end
      end
    endcase
  end

  assign sif.TX_DATA  = tx_data_q;
  assign sif.TX_READY = tx_ready_q;
  assign FIFO_COUNT   = count;
  assign FIFO_FULL    = full;
  assign OVERFLOW     = overflow_q;

endmodule

// File: tb/tb_uart_frame_streamer.sv
// tb_uart_frame_streamer
//   Directed bench for uart_frame_streamer with a small UART transmitter
//   model that drops IDLE for a configurable number of cycles per byte and
//   logs every strobed byte.
module tb_uart_frame_streamer;
  localparam int DEPTH_LOG2 = 4;

  logic                CLK;
  logic                RST_N;
  logic [DEPTH_LOG2:0] FIFO_COUNT;
  logic                FIFO_FULL;
  logic                OVERFLOW;

  uart_frame_streamer_if sif ();

  uart_frame_streamer #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .SYNC0     (8'hFF),
    .SYNC1     (8'h00),
    .CLAMP     (1'b1)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .sif       (sif.master),
    .FIFO_COUNT(FIFO_COUNT),
    .FIFO_FULL (FIFO_FULL),
    .OVERFLOW  (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int         n_checks;
  int         n_fail;
  int         strobe_err;
  logic [7:0] sent_q [$];
  bit         tx_auto;
  bit         idle_force;
  int         byte_cyc;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Transmitter model: logs each strobe, flags strobes that are wider than
  // one cycle or raised while IDLE was low, then goes busy for byte_cyc.
  initial begin
    int busy;
    bit prev_rdy;
    busy       = 0;
    prev_rdy   = 1'b0;
    strobe_err = 0;
    sif.TX_IDLE = 1'b0;
    forever begin
      @(negedge CLK);
      if (sif.TX_READY === 1'b1) begin
        sent_q.push_back(sif.TX_DATA);
        if (sif.TX_IDLE !== 1'b1) strobe_err++;
        if (prev_rdy) strobe_err++;
      end
      prev_rdy = (sif.TX_READY === 1'b1);
      if (!tx_auto) begin
        busy = 0;
        sif.TX_IDLE = idle_force;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) sif.TX_IDLE = 1'b1;
      end else if (sif.TX_READY === 1'b1) begin
        sif.TX_IDLE = 1'b0;
        busy = byte_cyc;
      end else begin
        sif.TX_IDLE = 1'b1;
      end
    end
  end

  // One pixel sampled on the next rising edge; returns at the following
  // negedge.
  task automatic pix(input logic [7:0] d, input logic sof);
    sif.PIX_DATA    = d;
    sif.FRAME_START = sof;
    sif.PIX_VALID   = 1'b1;
    @(negedge CLK);
    sif.PIX_VALID   = 1'b0;
    sif.FRAME_START = 1'b0;
  endtask

  task automatic wait_sent(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (sent_q.size() < n && i < budget) begin
      @(negedge CLK);
      i++;
    end
    check_val(tag, sent_q.size(), n);
  endtask

  // Returns at the negedge inside the strobe cycle.
  task automatic wait_tx_ready(input string tag, input logic [7:0] d, input bit match_d,
                               input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge CLK);
      if (sif.TX_READY === 1'b1 && (!match_d || sif.TX_DATA == d)) found = 1'b1;
    end
    check_val(tag, found, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base;
    int         base2;
    logic [7:0] exp2 [5];
    exp2 = '{8'hFF, 8'h00, 8'h12, 8'h34, 8'hFE};

    n_checks   = 0;
    n_fail     = 0;
    tx_auto    = 1'b0;
    idle_force = 1'b0;
    byte_cyc   = 1000;

    // reset held for two edges with a valid pixel present
    sif.PIX_DATA    = 8'hA5;
    sif.PIX_VALID   = 1'b1;
    sif.FRAME_START = 1'b1;
    RST_N           = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_tx_data", sif.TX_DATA, 8'h00);
    check_val("rst_tx_ready", sif.TX_READY, 1'b0);
    check_val("rst_fifo_count", FIFO_COUNT, 0);
    check_val("rst_fifo_full", FIFO_FULL, 1'b0);
    check_val("rst_overflow", OVERFLOW, 1'b0);
    sif.PIX_VALID   = 1'b0;
    sif.FRAME_START = 1'b0;
    RST_N           = 1'b1;
    @(negedge CLK);
    check_val("rst_release_count", FIFO_COUNT, 0);

    // frame with header; 10 us per byte at a 100 MHz clock
    tx_auto  = 1'b1;
    byte_cyc = 1000;
    base     = sent_q.size();
    repeat (2) @(negedge CLK);
    pix(8'h12, 1'b1);
    pix(8'h34, 1'b0);
    pix(8'hFF, 1'b0);
    wait_sent("frame_done", base + 5, 8000);
    for (int i = 0; i < 5; i++) begin
      if (sent_q.size() > base + i) check_val($sformatf("frame_byte%0d", i), sent_q[base + i], exp2[i]);
    end
    repeat (1500) @(negedge CLK);
    check_val("frame_strobe_count", sent_q.size(), base + 5);
    check_val("frame_strobe_rules", strobe_err, 0);
    check_val("frame_fifo_empty", FIFO_COUNT, 0);

    // single byte latency with IDLE held high
    tx_auto    = 1'b0;
    idle_force = 1'b1;
    repeat (3) @(negedge CLK);
    base = sent_q.size();
    pix(8'h5A, 1'b0);
    check_val("lat_k_count", FIFO_COUNT, 1);
    check_val("lat_k_ready", sif.TX_READY, 1'b0);
    @(negedge CLK);
    check_val("lat_k1_count", FIFO_COUNT, 0);
    check_val("lat_k1_ready", sif.TX_READY, 1'b0);
    check_val("lat_k1_data", sif.TX_DATA, 8'h5A);
    @(negedge CLK);
    check_val("lat_k2_ready", sif.TX_READY, 1'b1);
    @(negedge CLK);
    check_val("lat_k3_ready", sif.TX_READY, 1'b0);
    @(negedge CLK);
    check_val("lat_k4_ready", sif.TX_READY, 1'b0);
    check_val("lat_strobes", sent_q.size(), base + 1);

    // fill to overflow with IDLE low. A blocker byte is taken into the
    // holding register first so the 17 pixels see only the 16-entry FIFO.
    idle_force = 1'b0;
    repeat (3) @(negedge CLK);
    base = sent_q.size();
    pix(8'hB0, 1'b0);
    @(negedge CLK);
    check_val("fill_blocker_popped", FIFO_COUNT, 0);
    for (int i = 0; i < 17; i++) begin
      pix(8'h20 + 8'(i), 1'b0);
      if (i == 15) begin
        check_val("fill16_full", FIFO_FULL, 1'b1);
        check_val("fill16_overflow", OVERFLOW, 1'b0);
      end
    end
    check_val("fill17_full", FIFO_FULL, 1'b1);
    check_val("fill17_count", FIFO_COUNT, 16);
    check_val("fill17_overflow", OVERFLOW, 1'b1);
    byte_cyc = 8;
    tx_auto  = 1'b1;
    wait_sent("fill_drain", base + 17, 600);
    if (sent_q.size() >= base + 17) begin
      check_val("fill_blocker", sent_q[base], 8'hB0);
      for (int i = 0; i < 16; i++) begin
        check_val($sformatf("fill_byte%0d", i), sent_q[base + 1 + i], 8'h20 + 8'(i));
      end
    end
    repeat (50) @(negedge CLK);
    check_val("fill_no_extra", sent_q.size(), base + 17);
    check_val("fill_overflow_sticky", OVERFLOW, 1'b1);

    // full FIFO with simultaneous push and pop
    tx_auto    = 1'b0;
    idle_force = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check_val("pp_rst_overflow", OVERFLOW, 1'b0);
    check_val("pp_rst_count", FIFO_COUNT, 0);
    base = sent_q.size();
    pix(8'hB1, 1'b0);
    @(negedge CLK);
    for (int i = 0; i < 16; i++) pix(8'h40 + 8'(i), 1'b0);
    check_val("pp_full", FIFO_FULL, 1'b1);
    tx_auto = 1'b1;
    wait_tx_ready("pp_blocker_strobe", 8'hB1, 1'b1, 100);
    @(negedge CLK);
    pix(8'h5F, 1'b0);
    check_val("pp_count", FIFO_COUNT, 16);
    check_val("pp_full_after", FIFO_FULL, 1'b1);
    check_val("pp_overflow", OVERFLOW, 1'b0);
    wait_sent("pp_drain", base + 18, 600);
    if (sent_q.size() >= base + 18) begin
      check_val("pp_byte_first", sent_q[base + 1], 8'h40);
      check_val("pp_byte_16", sent_q[base + 16], 8'h4F);
      check_val("pp_byte_last", sent_q[base + 17], 8'h5F);
    end
    check_val("pp_overflow_end", OVERFLOW, 1'b0);

    // reset while in SYNC1
    base = sent_q.size();
    pix(8'h77, 1'b1);
    pix(8'h44, 1'b0);
    wait_tx_ready("s1_sync0_strobe", 8'hFF, 1'b1, 100);
    @(negedge CLK);
    check_val("s1_in_sync1", sif.TX_DATA, 8'h00);
    check_val("s1_count", FIFO_COUNT, 1);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check_val("s1_rst_ready", sif.TX_READY, 1'b0);
    check_val("s1_rst_count", FIFO_COUNT, 0);
    check_val("s1_rst_data", sif.TX_DATA, 8'h00);
    base2 = sent_q.size();
    pix(8'h66, 1'b1);
    wait_sent("s1_restart", base2 + 3, 200);
    if (sent_q.size() >= base2 + 3) begin
      check_val("s1_restart_b0", sent_q[base2], 8'hFF);
      check_val("s1_restart_b1", sent_q[base2 + 1], 8'h00);
      check_val("s1_restart_b2", sent_q[base2 + 2], 8'h66);
    end
    repeat (60) @(negedge CLK);
    check_val("s1_no_stale", sent_q.size(), base2 + 3);

    check_val("strobe_rules_total", strobe_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
